// File: rtl/divclk_ctrl_060.sv
// Programmable slow-clock divider with a two-client round-robin ratio update port.
// Outputs registered (no extra lag); a client's request waits while a prior ratio is pending.
module divclk_ctrl_060 #(
   parameter int unsigned DIV_W       = 32,
   parameter int unsigned DEFAULT_DIV = 200_000,
   parameter int unsigned MIN_DIV     = 2
) (
   input  logic             inclk_060,
   input  logic             rst_060,
   input  logic             en_060,
   input  logic             req_a_060,
   input  logic [DIV_W-1:0] div_a_060,
   output logic             ack_a_060,
   input  logic             req_b_060,
   input  logic [DIV_W-1:0] div_b_060,
   output logic             ack_b_060,
   output logic             outclk_060,
   output logic             tick_060,
   output logic             busy_060,
   output logic [DIV_W-1:0] cur_div_060
);

   localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] pend;
   logic [DIV_W-1:0] cur_div_nxt;
   logic [DIV_W-1:0] half_nxt;
   logic [DIV_W-1:0] div_sel;
   logic [DIV_W-1:0] div_clamp;

   logic             boundary;
   logic             apply;
   logic             last_b;
   logic             elig_a;
   logic             elig_b;
   logic             grant_a;
   logic             grant_b;
   logic             outclk_nxt;
   logic             tick_nxt;

   assign boundary = (state != IDLE) && (cnt == (cur_div_060 - ONE_V));

   // A pending ratio lands immediately when stopped, otherwise only at a period boundary.
   assign apply = busy_060 && ((state == IDLE) || boundary);

   // A requester still seeing its ack this cycle has not had a chance to drop req yet.
   assign elig_a  = req_a_060 && !ack_a_060;
   assign elig_b  = req_b_060 && !ack_b_060;
   assign grant_a = !busy_060 && elig_a && (!elig_b || last_b);
   assign grant_b = !busy_060 && elig_b && (!elig_a || !last_b);

   assign div_sel   = grant_a ? div_a_060 : div_b_060;
   assign div_clamp = (div_sel < MIN_DIV_V) ? MIN_DIV_V : div_sel;

   always_ff @(posedge inclk_060) begin
      if (rst_060) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en_060) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!en_060) begin
               state_nxt = boundary ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            if (en_060) begin
               state_nxt = RUN;
            end else if (boundary) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_nxt     = ((state == IDLE) || boundary) ? '0 : (cnt + ONE_V);
      cur_div_nxt = apply ? pend : cur_div_060;
      half_nxt    = cur_div_nxt >> 1;
   end

   // Outputs are derived from next-state values so the registered waveform has no added lag.
   always_comb begin
      outclk_nxt = (state_nxt != IDLE) && (cnt_nxt >= half_nxt);
      tick_nxt   = (state_nxt != IDLE) && (cnt_nxt == half_nxt);
   end

   always_ff @(posedge inclk_060) begin
      if (rst_060) begin
         cnt         <= '0;
         cur_div_060 <= DEF_DIV_V;
         pend        <= '0;
         busy_060    <= 1'b0;
         ack_a_060   <= 1'b0;
         ack_b_060   <= 1'b0;
         last_b      <= 1'b1;
         outclk_060  <= 1'b0;
         tick_060    <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         cur_div_060 <= cur_div_nxt;
         ack_a_060   <= grant_a;
         ack_b_060   <= grant_b;
         outclk_060  <= outclk_nxt;
         tick_060    <= tick_nxt;
         if (grant_a || grant_b) begin
            pend     <= div_clamp;
            last_b   <= grant_b;
            busy_060 <= 1'b1;
         end else if (apply) begin
            busy_060 <= 1'b0;
         end
      end
   end

   a_cnt_bound: assert property (@(posedge inclk_060) disable iff (rst_060)
      cnt < cur_div_060);

   a_outclk_phase: assert property (@(posedge inclk_060) disable iff (rst_060)
      outclk_060 == ((state != IDLE) && (cnt >= (cur_div_060 >> 1))));

endmodule

// File: doc/divclk_ctrl_060.md
Name: divclk_ctrl_060

Overview:
Runtime controller for the board's programmable slow-clock divider, with a divider core built in.
- Two client blocks share one divide-ratio register (e.g. motor PWM scheduler and sensor poller); a round-robin arbiter decides which request is taken.
- Accepted ratios take effect only at a period boundary, so the output clock never glitches.
- Generates the enable-gated square wave outclk_060 and a one-cycle tick_060 strobe for downstream logic.

Parameters:
DIV_W, 32, width of divide ratios and the period counter
DEFAULT_DIV, 200_000, period in inclk_060 cycles after reset (gives 500 Hz from 100 MHz)
MIN_DIV, 2, smallest legal ratio; smaller requests are clamped up to this value

Ports:
inclk_060  in  1  system clock, 100 MHz
rst_060  in  1  synchronous reset, active-high
en_060  in  1  run enable for the divider
req_a_060  in  1  client A update request; held high until ack_a_060
div_a_060  in  DIV_W  client A requested ratio; stable while req_a_060 is high
ack_a_060  out  1  one-cycle acceptance pulse to client A
req_b_060  in  1  client B update request
div_b_060  in  DIV_W  client B requested ratio
ack_b_060  out  1  one-cycle acceptance pulse to client B
outclk_060  out  1  divided clock, registered
tick_060  out  1  one-cycle pulse coincident with each rising edge of outclk_060
busy_060  out  1  accepted ratio is pending, not yet applied
cur_div_060  out  DIV_W  ratio currently in effect

Behaviour:
- Interface: one clock, inclk_060. Reset rst_060 is synchronous and active-high.

Reset values:
- cnt=0, cur_div_060=DEFAULT_DIV, pending empty.
- outclk_060, tick_060, ack_a/b_060, busy_060 all 0.
- State IDLE; round-robin pointer set so A wins the first tie.
- Reset asserted mid-period or mid-handshake aborts everything; a request still held high is re-arbitrated after reset releases.

Registers:
- half = cur_div>>1.
- Invariant after every edge: outclk_060 == (state!=IDLE && cnt>=half). Compute it from the next-state cnt so there is no extra lag.
- tick_060 = 1 in exactly the cycles where cnt==half, state!=IDLE.

FSM:
- IDLE: cnt held 0, outclk low. en_060=1 -> RUN, with cnt=0 on the next edge.
- RUN: cnt increments each cycle. At cnt==cur_div-1, cnt wraps to 0 (the boundary). en_060=0 -> DRAIN, or -> IDLE directly if the same cycle is a boundary.
- DRAIN: keeps counting to the boundary, then -> IDLE. en_060 returning to 1 -> RUN with no counter disturbance.

Arbitration and handshake:
- A request is accepted only when pending is empty.
- A requester whose ack is high this cycle is ineligible this cycle.
- If both A and B are eligible, the one not granted last wins; the pointer updates on every grant.
- On acceptance: pend <= max(div_x, MIN_DIV), busy_060=1 on the next edge, ack_x=1 on the next edge for one cycle.
- Requests arriving while busy_060=1 wait (no ack); the data must stay stable.

Apply rules:
- RUN/DRAIN: pend loads into cur_div_060 at a boundary, cnt=0, busy clears.
- IDLE: pend applies on the cycle after acceptance.
- A grant in the same cycle as a boundary is not applied at that boundary; it waits for the next one.
- Odd ratios: the low phase has half cycles and the high phase has cur_div-half cycles.
- No overflow: cnt never exceeds cur_div-1.

Test Plan:
1. DEFAULT_DIV=10. Reset, en_060=1 -> outclk low 5 cycles / high 5 cycles; tick_060 every 10 cycles; cur_div_060=10.
2. While running at 10, A requests 4 at cnt=2 -> ack_a next cycle, busy=1 until cnt wraps 9->0. Afterwards period=4 (2 low/2 high), busy=0.
3. A(6) and B(8) request in the same cycle after reset -> A acked first. B acked only after A's value applies. Next simultaneous tie goes to A again because B was last granted.
4. Request div=0 in IDLE -> cur_div_060=2 one cycle after ack; en=1 gives period 2 (1 low/1 high), tick every 2 cycles.
5. en_060 dropped at cnt=3 of 10 -> counting continues to 9, then IDLE with outclk=0. Re-raising en at cnt=7 instead -> no gap or phase change.
6. rst_060 pulsed at cnt=7 with busy=1 -> next cycle cnt=0, outclk=0, busy=0, cur_div=DEFAULT_DIV; a held req is re-acked after release.
